// File: rtl/intra_net_pkg.sv
// Shared FSM encoding and default widths for the output-buffer to activation-buffer transfer path.
// Used by intra_net_xfer_ctrl and intra_net_requant.
package intra_net_pkg;

    localparam int DEF_OUT_DATA_WIDTH = 32;
    localparam int DEF_ACT_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH     = 10;
    localparam int DEF_DIM_WIDTH      = 8;
    localparam int DEF_SHIFT_WIDTH    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } xfer_state_t;

endpackage

// File: rtl/intra_net_requant.sv
// Combinational requantizer: round half up, arithmetic shift right, saturate to the activation range.
// Build option INTRA_NET_RELU_EN clamps negative results to zero before saturation.
module intra_net_requant
    import intra_net_pkg::*;
#(
    parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
    parameter int ACT_DATA_WIDTH = DEF_ACT_DATA_WIDTH,
    parameter int SHIFT_WIDTH    = DEF_SHIFT_WIDTH
) (
    input  logic [OUT_DATA_WIDTH-1:0] data,
    input  logic [SHIFT_WIDTH-1:0]    shift,
    output logic [ACT_DATA_WIDTH-1:0] result
);

    // One guard bit keeps the rounding add from overflowing.
    localparam int XW = OUT_DATA_WIDTH + 1;
    localparam logic signed [XW-1:0] ACT_MAX = XW'((64'sd1 <<< (ACT_DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [XW-1:0] ACT_MIN = ~ACT_MAX;

    logic signed [XW-1:0] wide;
    logic signed [XW-1:0] rnd;
    logic signed [XW-1:0] shifted;
    logic signed [XW-1:0] clipped;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        wide    = XW'($signed(data));
        rnd     = '0;
        if (shift != '0) begin
            rnd = XW'(1) << (shift - SHIFT_WIDTH'(1));
        end
        shifted = (wide + rnd) >>> shift;
        clipped = shifted;
`ifdef INTRA_NET_RELU_EN
        if (shifted[XW-1]) begin
            clipped = '0;
        end
`endif
        if (clipped > ACT_MAX) begin
            result = ACT_MAX[ACT_DATA_WIDTH-1:0];
        end else if (clipped < ACT_MIN) begin
            result = ACT_MIN[ACT_DATA_WIDTH-1:0];
        end else begin
            result = clipped[ACT_DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/intra_net_xfer_ctrl.sv
// Walks a row x col tile of the output buffer, requantizes each word and writes it to the activation buffer.
// Build option INTRA_NET_RELU_EN selects ReLU clamping in the requantizer; ports and timing are unchanged.
module intra_net_xfer_ctrl
    import intra_net_pkg::*;
#(
    parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
    parameter int ACT_DATA_WIDTH = DEF_ACT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH      = DEF_DIM_WIDTH,
    parameter int SHIFT_WIDTH    = DEF_SHIFT_WIDTH,
    parameter int RD_LAT         = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     o_base_addr,
    input  logic [ADDR_WIDTH-1:0]     a_base_addr,
    input  logic [DIM_WIDTH-1:0]      num_of_col,
    input  logic [DIM_WIDTH-1:0]      num_of_row,
    input  logic [SHIFT_WIDTH-1:0]    shift,
    input  logic                      hold,
    output logic                      busy,
    output logic                      done,
    output logic                      o_rd_en,
    output logic [ADDR_WIDTH-1:0]     o_addr,
    input  logic [OUT_DATA_WIDTH-1:0] o_rd_data,
    output logic                      a_w_en,
    output logic [ADDR_WIDTH-1:0]     a_addr,
    output logic [ACT_DATA_WIDTH-1:0] a_w_data
);

    localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    xfer_state_t              state;
    logic [ADDR_WIDTH-1:0]    o_base_q;
    logic [ADDR_WIDTH-1:0]    a_base_q;
    logic [DIM_WIDTH-1:0]     cols_q;
    logic [DIM_WIDTH-1:0]     rows_q;
    logic [SHIFT_WIDTH-1:0]   shift_q;
    logic [DIM_WIDTH-1:0]     col;
    logic [DIM_WIDTH-1:0]     row;
    logic [ADDR_WIDTH-1:0]    ptr;

    // Shadow pipeline: one slot per read-latency cycle, carrying the linear index with each read.
    logic [RD_LAT-1:0]        pipe_vld;
    logic [ADDR_WIDTH-1:0]    pipe_idx [RD_LAT];

    logic [ACT_DATA_WIDTH-1:0] rq_data;
    logic                      issue;
    logic                      wrap_col;
    logic                      last_elem;

    // Reads respond to hold in the same cycle, so issue is decoded from the state register.
    assign issue     = (state == RUN) && !hold;
    assign wrap_col  = (col == cols_q - DIM_ONE);
    assign last_elem = wrap_col && (row == rows_q - DIM_ONE);
    assign o_rd_en   = issue;
    assign o_addr    = issue ? (o_base_q + ptr) : '0;

    intra_net_requant #(
        .OUT_DATA_WIDTH (OUT_DATA_WIDTH),
        .ACT_DATA_WIDTH (ACT_DATA_WIDTH),
        .SHIFT_WIDTH    (SHIFT_WIDTH)
    ) u_requant (
        .data   (o_rd_data),
        .shift  (shift_q),
        .result (rq_data)
    );

    // NOTE: the index payload has no reset; only the valid bits decide whether a slot is live.
    always_ff @(posedge clk) begin
        pipe_idx[0] <= ptr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_idx[i] <= pipe_idx[i-1];
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            o_base_q <= '0;
            a_base_q <= '0;
            cols_q   <= '0;
            rows_q   <= '0;
            shift_q  <= '0;
            col      <= '0;
            row      <= '0;
            ptr      <= '0;
            pipe_vld <= '0;
            a_w_en   <= 1'b0;
            a_addr   <= '0;
            a_w_data <= '0;
        end else begin
            done <= 1'b0;

            pipe_vld[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end

            // Data, address and enable of a write are registered together.
            a_w_en <= pipe_vld[RD_LAT-1];
            if (pipe_vld[RD_LAT-1]) begin
                a_addr   <= a_base_q + pipe_idx[RD_LAT-1];
                a_w_data <= rq_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        o_base_q <= o_base_addr;
                        a_base_q <= a_base_addr;
                        cols_q   <= num_of_col;
                        rows_q   <= num_of_row;
                        shift_q  <= shift;
                        col      <= '0;
                        row      <= '0;
                        ptr      <= '0;
                        busy     <= 1'b1;
                        if (num_of_col == '0 || num_of_row == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (!hold) begin
                        ptr <= ptr + ADDR_ONE;
                        if (wrap_col) begin
                            col <= '0;
                            row <= row + DIM_ONE;
                        end else begin
                            col <= col + DIM_ONE;
                        end
                        if (last_elem) begin
                            state <= DRAIN;
                        end
                    end
                end

                // The write register retires its last entry in the cycle the pipeline runs empty.
                DRAIN: begin
                    if (pipe_vld == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
